// File: rtl/seg_message_driver.sv
// seg_message_driver
//   Drives a 4-digit 7-segment display from UART bytes. The last four received
//   characters are kept in a scrolling buffer, and the newest one appears on the
//   rightmost digit. The scanner's digit select picks which slot is shown. After
//   every select change the anodes stay off for BLANK_CYCLES clocks, which stops
//   the previous digit's segments from ghosting onto the new one.
// Ports
//   clk, reset  system clock; synchronous active-high reset
//   array_sel   digit select from the scanner (0 = rightmost, an[0])
//   rx_data     received byte; it is valid while rx_valid is high
//   rx_valid    1-clk strobe from the UART receiver
//   clear       1-clk strobe that empties the buffer
//   an          digit anodes, active-low
//   seg         cathodes {g,f,e,d,c,b,a}, active-low
//   dp          decimal point, active-low
module seg_message_driver #(
  parameter int BLANK_CYCLES = 4,
  parameter bit CR_CLEARS    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] array_sel,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       clear,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  // When BLANK_CYCLES is 0 the counter keeps one bit and never loads a
  // nonzero value.
  localparam int CW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYCLES);

  typedef struct packed {
    logic       valid;
    logic [7:0] ch;
    logic       dpf;
  } slot_t;

  slot_t [3:0] slot, slot_nx;
  logic [1:0]    sel_q;
  logic [CW-1:0] cnt, cnt_nx;
  slot_t         cur;
  logic          is_eol;

  function automatic logic [6:0] decode(input logic [7:0] c);
    case (c)
      8'h30:        decode = 7'b1000000;
      8'h31:        decode = 7'b1111001;
      8'h32:        decode = 7'b0100100;
      8'h33:        decode = 7'b0110000;
      8'h34:        decode = 7'b0011001;
      8'h35:        decode = 7'b0010010;
      8'h36:        decode = 7'b0000010;
      8'h37:        decode = 7'b1111000;
      8'h38:        decode = 7'b0000000;
      8'h39:        decode = 7'b0010000;
      8'h41, 8'h61: decode = 7'b0001000;
      8'h42, 8'h62: decode = 7'b0000011;
      8'h43, 8'h63: decode = 7'b1000110;
      8'h44, 8'h64: decode = 7'b0100001;
      8'h45, 8'h65: decode = 7'b0000110;
      8'h46, 8'h66: decode = 7'b0001110;
      8'h2D:        decode = 7'b0111111;
      8'h20:        decode = 7'b1111111;
      default:      decode = 7'b1110111;
    endcase
  endfunction

  // Buffer update. Clear and end-of-line take priority over any byte that
  // arrives in the same cycle, and that byte is dropped.
  always_comb begin
    slot_nx = slot;
    is_eol  = CR_CLEARS && rx_valid && (rx_data == 8'h0D || rx_data == 8'h0A);
    if (clear || is_eol) begin
      for (int i = 0; i < 4; i++) begin
        slot_nx[i].valid = 1'b0;
        slot_nx[i].dpf   = 1'b0;
      end
    end else if (rx_valid && rx_data == 8'h2E) begin
      // A '.' attaches to the newest character. With nothing to attach to,
      // it becomes a space that shows only the decimal point.
      if (slot[0].valid) slot_nx[0].dpf = 1'b1;
      else               slot_nx = {slot[2], slot[1], slot[0], slot_t'{1'b1, 8'h20, 1'b1}};
    end else if (rx_valid) begin
      slot_nx = {slot[2], slot[1], slot[0], slot_t'{1'b1, rx_data, 1'b0}};
    end
  end

  always_comb begin
    if (array_sel != sel_q) cnt_nx = BLANK_LD;
    else if (cnt != '0)     cnt_nx = cnt - CW'(1);
    else                    cnt_nx = cnt;
  end

  assign cur = slot[sel_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      slot  <= '0;
      sel_q <= 2'd0;
      cnt   <= '0;
      an    <= 4'b1111;
      seg   <= 7'h7F;
      dp    <= 1'b1;
    end else begin
      slot  <= slot_nx;
      sel_q <= array_sel;
      cnt   <= cnt_nx;
      if (cnt_nx != '0) begin
        // While blanking, seg and dp keep their values so that only the
        // anodes switch.
        an <= 4'b1111;
      end else begin
        an  <= ~(4'b0001 << sel_q);
        seg <= cur.valid ? decode(cur.ch) : 7'h7F;
        dp  <= cur.valid ? ~cur.dpf : 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_message_driver.sv
module tb_seg_message_driver;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] array_sel = 2'd0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] an, an2;
  logic [6:0] seg, seg2;
  logic       dp, dp2;

  always #5 clk = ~clk;

  // u0: default build. u1: no CR/LF clearing and a shorter blank time.
  seg_message_driver #(.BLANK_CYCLES(4), .CR_CLEARS(1'b1)) u0 (
    .clk(clk), .reset(reset), .array_sel(array_sel), .rx_data(rx_data),
    .rx_valid(rx_valid), .clear(clear), .an(an), .seg(seg), .dp(dp));
  seg_message_driver #(.BLANK_CYCLES(2), .CR_CLEARS(1'b0)) u1 (
    .clk(clk), .reset(reset), .array_sel(array_sel), .rx_data(rx_data),
    .rx_valid(rx_valid), .clear(clear), .an(an2), .seg(seg2), .dp(dp2));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  // Each buffer is a queue with the newest character at the front. Only the
  // characters held in the queue count as valid.
  typedef struct {
    bit [7:0] ch;
    bit       dpf;
  } ent_t;

  ent_t q0[$], q1[$];
  int         blk[2] = '{4, 2};
  bit         crc[2] = '{1'b1, 1'b0};
  logic [1:0] sp[2];
  int         since[2];
  logic [3:0] ean[2];
  logic [6:0] eseg[2];
  logic       edp[2];
  bit         started = 1'b0;

  function automatic logic [6:0] glyph(input bit [7:0] c);
    logic [6:0] hexg[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    if (c >= "0" && c <= "9") return hexg[c - "0"];
    if (c >= "A" && c <= "F") return hexg[c - "A" + 10];
    if (c >= "a" && c <= "f") return hexg[c - "a" + 10];
    if (c == "-") return 7'b0111111;
    if (c == " ") return 7'h7F;
    return 7'b1110111;
  endfunction

  task automatic mstep(input int m);
    ent_t q[$];
    ent_t e;
    if (m == 0) q = q0; else q = q1;
    if (reset) begin
      q.delete();
      sp[m] = 2'd0; since[m] = 1000;
      ean[m] = 4'b1111; eseg[m] = 7'h7F; edp[m] = 1'b1;
    end else begin
      // The display uses the buffer as it was before this edge.
      if (array_sel != sp[m]) since[m] = 0;
      else if (since[m] < 1000) since[m]++;
      if (since[m] < blk[m]) ean[m] = 4'b1111;
      else begin
        ean[m] = 4'b1111;
        ean[m][sp[m]] = 1'b0;
        if (int'(sp[m]) < q.size()) begin
          eseg[m] = glyph(q[sp[m]].ch); edp[m] = ~q[sp[m]].dpf;
        end else begin
          eseg[m] = 7'h7F; edp[m] = 1'b1;
        end
      end
      sp[m] = array_sel;
      if (clear || (crc[m] && rx_valid && (rx_data == 8'h0D || rx_data == 8'h0A)))
        q.delete();
      else if (rx_valid && rx_data == 8'h2E) begin
        if (q.size() > 0) q[0].dpf = 1'b1;
        else begin e.ch = 8'h20; e.dpf = 1'b1; q.push_front(e); end
      end else if (rx_valid) begin
        e.ch = rx_data; e.dpf = 1'b0; q.push_front(e);
        if (q.size() > 4) void'(q.pop_back());
      end
    end
    if (m == 0) q0 = q; else q1 = q;
  endtask

  // The model advances on each edge, and the comparison runs 2 time units later.
  initial forever begin
    @(posedge clk);
    mstep(0); mstep(1);
    if (reset) started = 1'b1;
    #2;
    if (started) begin
      chk("an0", an, ean[0]);   chk("seg0", seg, eseg[0]);   chk("dp0", dp, edp[0]);
      chk("an1", an2, ean[1]);  chk("seg1", seg2, eseg[1]);  chk("dp1", dp2, edp[1]);
    end
  end

  // ---------------- stimulus ----------------
  logic [1:0] cur_sel = 2'd0;

  task automatic drive(input logic r, input logic [1:0] s, input logic [7:0] d,
                       input logic v, input logic c);
    @(negedge clk);
    reset = r; array_sel = s; cur_sel = s; rx_data = d; rx_valid = v; clear = c;
  endtask

  task automatic tick();
    @(posedge clk); #3;
  endtask

  task automatic send(input logic [7:0] d);
    drive(1'b0, cur_sel, d, 1'b1, 1'b0);
  endtask

  task automatic do_clear();
    drive(1'b0, cur_sel, 8'h00, 1'b0, 1'b1);
  endtask

  // Select digit s, wait out the blanking, and leave the outputs settled.
  task automatic show(input logic [1:0] s);
    drive(1'b0, s, 8'h00, 1'b0, 1'b0);
    repeat (4) drive(1'b0, s, 8'h00, 1'b0, 1'b0);
    tick();
  endtask

  string pool = "0123456789ABCDEFabcdef";

  initial begin
    // 1: reset values, then an empty rightmost digit
    repeat (3) @(posedge clk);
    #3;
    chk("rst_an", an, 4'b1111); chk("rst_seg", seg, 7'h7F); chk("rst_dp", dp, 1'b1);
    drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("rel_an", an, 4'b1110); chk("rel_seg", seg, 7'h7F);

    // 2: five bytes scroll the oldest one out
    send("1"); send("2"); send("3"); send("4"); send("5");
    show(2'd0); chk("d0_an", an, 4'b1110); chk("d0_seg5", seg, 7'b0010010);
    chk("model_pin5", eseg[0], 7'b0010010);
    show(2'd1); chk("d1_an", an, 4'b1101); chk("d1_seg4", seg, 7'b0011001);
    show(2'd2); chk("d2_an", an, 4'b1011); chk("d2_seg3", seg, 7'b0110000);
    show(2'd3); chk("d3_an", an, 4'b0111); chk("d3_seg2", seg, 7'b0100100);

    // 3: decimal point handling
    do_clear(); send("7"); send(8'h2E);
    show(2'd0); chk("dot7_seg", seg, 7'b1111000); chk("dot7_dp", dp, 1'b0);
    do_clear(); send(8'h2E);
    show(2'd0); chk("dotE_seg", seg, 7'h7F); chk("dotE_dp", dp, 1'b0);

    // 4: blanking for exactly BLANK_CYCLES edges, then a select toggled on every clock
    drive(1'b0, 2'd1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin tick(); chk("blank_an", an, 4'b1111); end
    tick(); chk("unblank_an", an, 4'b1101);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, (i % 2 == 0) ? 2'd0 : 2'd1, 8'h00, 1'b0, 1'b0);
      tick(); chk("toggle_an", an, 4'b1111);
    end

    // 5: clear wins over a byte in the same cycle, and CR/LF handling
    send("9");
    drive(1'b0, cur_sel, "A", 1'b1, 1'b1);
    for (int s = 0; s < 4; s++) begin show(2'(s)); chk("clr_seg", seg, 7'h7F); end
    do_clear(); send("A"); send(8'h0D);
    show(2'd0); chk("cr_seg", seg, 7'h7F); chk("cr0_seg_u1", seg2, 7'b1110111);
    show(2'd1); chk("cr1_seg_u1", seg2, 7'b0001000);

    // 6: reset during blanking with three characters buffered
    do_clear(); send("a"); send("b"); send("c");
    drive(1'b0, 2'd2, 8'h00, 1'b0, 1'b0);
    tick();
    drive(1'b1, 2'd2, 8'h00, 1'b0, 1'b0);
    tick();
    chk("midrst_an", an, 4'b1111); chk("midrst_seg", seg, 7'h7F); chk("midrst_dp", dp, 1'b1);
    for (int s = 0; s < 4; s++) begin show(2'(s)); chk("midrst_empty", seg, 7'h7F); end

    // random traffic, checked by the model on every cycle
    begin
      int burst = 0;
      for (int n = 0; n < 3000; n++) begin
        logic r, v, c;
        logic [7:0] d;
        logic [1:0] s;
        int k;
        r = ($urandom_range(0, 199) == 0);
        c = ($urandom_range(0, 39) == 0);
        v = ($urandom_range(0, 2) == 0);
        k = $urandom_range(0, 9);
        case (k)
          0: d = 8'h2E;
          1: d = 8'h0D;
          2: d = 8'h0A;
          3: d = "-";
          4: d = " ";
          5, 6, 7: d = pool[$urandom_range(0, 21)];
          default: d = 8'($urandom);
        endcase
        s = cur_sel;
        if (burst > 0) begin s = 2'($urandom); burst--; end
        else if ($urandom_range(0, 30) == 0) burst = $urandom_range(2, 8);
        else if ($urandom_range(0, 7) == 0) s = 2'($urandom);
        drive(r, s, d, v, c);
      end
    end
    drive(1'b0, cur_sel, 8'h00, 1'b0, 1'b0);
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
